// File: rtl/game_pkg.sv
// game_pkg
// Shared definitions for the game datapath: screen position widths, the
// default car/obstacle sizes used by the obstacle generator, the renderer
// and the collision stage, and the externally visible game_state encoding.
package game_pkg;

    // Position widths: 10-bit column (0..639), 9-bit line (0..479)
    localparam int H_POS_W = 10;
    localparam int V_POS_W = 9;

    // Default sprite geometry
    localparam int CAR_W_DEF     = 40;
    localparam int CAR_H_DEF     = 60;
    localparam int CAR_V_POS_DEF = 400;
    localparam int OBS_W_DEF     = 50;
    localparam int OBS_H_DEF     = 50;

    // game_state output encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PLAYING  = 2'd1;
    localparam logic [1:0] ST_CRASH    = 2'd2;
    localparam logic [1:0] ST_GAMEOVER = 2'd3;

endpackage

// File: rtl/box_overlap.sv
// box_overlap
// Purely combinational axis-aligned bounding-box overlap test between box A
// (size A_W x A_H) and box B (size B_W x B_H), given their top-left corners.
// Edges that only touch do not count as overlap.
// Ports:
//   i_a_h, i_a_v  box A left column / top line
//   i_b_h, i_b_v  box B left column / top line
//   o_overlap     1 when the two boxes share at least one pixel
module box_overlap #(
    parameter int H_W = 10,
    parameter int V_W = 9,
    parameter int A_W = 40,
    parameter int A_H = 60,
    parameter int B_W = 50,
    parameter int B_H = 50
) (
    input  logic [H_W-1:0] i_a_h,
    input  logic [V_W-1:0] i_a_v,
    input  logic [H_W-1:0] i_b_h,
    input  logic [V_W-1:0] i_b_v,
    output logic           o_overlap
);

    // One bit wider than the widest position so the far-edge sums cannot wrap
    localparam int SUM_W = ((H_W > V_W) ? H_W : V_W) + 1;

    logic [SUM_W-1:0] w_ah;
    logic [SUM_W-1:0] w_av;
    logic [SUM_W-1:0] w_bh;
    logic [SUM_W-1:0] w_bv;
    logic             w_h_ov;
    logic             w_v_ov;

    assign w_ah = SUM_W'(i_a_h);
    assign w_av = SUM_W'(i_a_v);
    assign w_bh = SUM_W'(i_b_h);
    assign w_bv = SUM_W'(i_b_v);

    assign w_h_ov = (w_bh < w_ah + SUM_W'(A_W)) && (w_ah < w_bh + SUM_W'(B_W));
    assign w_v_ov = (w_bv < w_av + SUM_W'(A_H)) && (w_av < w_bv + SUM_W'(B_H));

    assign o_overlap = w_h_ov & w_v_ov;

endmodule

// File: rtl/collision_game_ctrl.sv
// collision_game_ctrl
// Game-control stage downstream of the obstacle generator. Detects car vs.
// obstacle overlap, runs the IDLE/PLAYING/CRASH/GAMEOVER state machine,
// tracks lives and a saturating frame score, and holds the obstacle
// generator in reset whenever the game is not being played.
// Ports:
//   iVGA_CLK               pixel clock
//   iRST                   asynchronous active-high reset
//   frame_tick             one-cycle pulse per frame
//   start_btn              debounced start button level
//   car_h_pos              car left column (car top line is fixed)
//   obs1_h_pos/obs1_v_pos  obstacle 1 top-left corner
//   obs2_h_pos/obs2_v_pos  obstacle 2 top-left corner
//   reset_game             1 = hold obstacle generator at its initial state
//   game_state             current state (game_pkg ST_* encoding)
//   lives                  remaining lives
//   score                  frames survived, saturating at 16'hFFFF
//   hit                    registered overlap flag
module collision_game_ctrl
    import game_pkg::*;
#(
    parameter int CAR_W        = CAR_W_DEF,
    parameter int CAR_H        = CAR_H_DEF,
    parameter int CAR_V_POS    = CAR_V_POS_DEF,
    parameter int OBS_W        = OBS_W_DEF,
    parameter int OBS_H        = OBS_H_DEF,
    parameter int LIVES_INI    = 3,
    parameter int CRASH_FRAMES = 60
) (
    input  logic               iVGA_CLK,
    input  logic               iRST,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic [H_POS_W-1:0] car_h_pos,
    input  logic [H_POS_W-1:0] obs1_h_pos,
    input  logic [H_POS_W-1:0] obs2_h_pos,
    input  logic [V_POS_W-1:0] obs1_v_pos,
    input  logic [V_POS_W-1:0] obs2_v_pos,
    output logic               reset_game,
    output logic [1:0]         game_state,
    output logic [1:0]         lives,
    output logic [15:0]        score,
    output logic               hit
);

    localparam int               CNT_W  = (CRASH_FRAMES > 1) ? $clog2(CRASH_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRASH_FRAMES - 1);
    localparam logic [1:0]       LIVES_LD = 2'(LIVES_INI);
    localparam logic [V_POS_W-1:0] CAR_V  = V_POS_W'(CAR_V_POS);

    logic [1:0]       r_state;
    logic             r_reset_game;
    logic [1:0]       r_lives;
    logic [15:0]      r_score;
    logic             r_hit;
    logic [CNT_W-1:0] r_crash_cnt;
    logic             r_start_d;

    logic w_ov1;
    logic w_ov2;
    logic w_start_rise;

    box_overlap #(
        .H_W(H_POS_W), .V_W(V_POS_W),
        .A_W(CAR_W),   .A_H(CAR_H),
        .B_W(OBS_W),   .B_H(OBS_H)
    ) u_ov1 (
        .i_a_h(car_h_pos),  .i_a_v(CAR_V),
        .i_b_h(obs1_h_pos), .i_b_v(obs1_v_pos),
        .o_overlap(w_ov1)
    );

    box_overlap #(
        .H_W(H_POS_W), .V_W(V_POS_W),
        .A_W(CAR_W),   .A_H(CAR_H),
        .B_W(OBS_W),   .B_H(OBS_H)
    ) u_ov2 (
        .i_a_h(car_h_pos),  .i_a_v(CAR_V),
        .i_b_h(obs2_h_pos), .i_b_v(obs2_v_pos),
        .o_overlap(w_ov2)
    );

    assign w_start_rise = start_btn & ~r_start_d;

    // reset_game is written alongside every state change so it tracks the
    // state register exactly rather than lagging it by a cycle.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            r_state      <= ST_IDLE;
            r_reset_game <= 1'b1;
            r_lives      <= LIVES_LD;
            r_score      <= '0;
            r_hit        <= 1'b0;
            r_crash_cnt  <= '0;
            r_start_d    <= 1'b1;  // button held through reset is not a press
        end else begin
            r_start_d <= start_btn;
            r_hit     <= w_ov1 | w_ov2;

            case (r_state)
                ST_IDLE, ST_GAMEOVER: begin
                    if (w_start_rise) begin
                        r_state      <= ST_PLAYING;
                        r_reset_game <= 1'b0;
                        r_lives      <= LIVES_LD;
                        r_score      <= '0;
                    end
                end
                ST_PLAYING: begin
                    if (frame_tick) begin
                        if (r_hit) begin
                            r_state      <= ST_CRASH;
                            r_reset_game <= 1'b1;
                            r_lives      <= r_lives - 2'd1;
                            r_crash_cnt  <= '0;
                        end else if (r_score != 16'hFFFF) begin
                            r_score <= r_score + 16'd1;
                        end
                    end
                end
                ST_CRASH: begin
                    if (frame_tick) begin
                        if (r_crash_cnt == CNT_LAST) begin
                            r_crash_cnt <= '0;
                            if (r_lives == 2'd0) begin
                                r_state      <= ST_GAMEOVER;
                                r_reset_game <= 1'b1;
                            end else begin
                                r_state      <= ST_PLAYING;
                                r_reset_game <= 1'b0;
                            end
                        end else begin
                            r_crash_cnt <= r_crash_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_reset_game <= 1'b1;
                end
            endcase
        end
    end

    assign reset_game = r_reset_game;
    assign game_state = r_state;
    assign lives      = r_lives;
    assign score      = r_score;
    assign hit        = r_hit;

endmodule

// File: tb/tb_collision_game_ctrl.sv
// tb_collision_game_ctrl
// Directed, table-driven bench for collision_game_ctrl: each record holds the
// inputs for one clock and the outputs expected after that clock edge.
module tb_collision_game_ctrl;

    localparam logic [1:0] S_ID = 2'd0;
    localparam logic [1:0] S_PL = 2'd1;
    localparam logic [1:0] S_CR = 2'd2;
    localparam logic [1:0] S_GO = 2'd3;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        start;
    logic [9:0]  car_h;
    logic [9:0]  o1_h;
    logic [9:0]  o2_h;
    logic [8:0]  o1_v;
    logic [8:0]  o2_v;
    logic        rg;
    logic [1:0]  st;
    logic [1:0]  lv;
    logic [15:0] sc;
    logic        hit;

    collision_game_ctrl dut (
        .iVGA_CLK(clk), .iRST(rst), .frame_tick(tick), .start_btn(start),
        .car_h_pos(car_h), .obs1_h_pos(o1_h), .obs2_h_pos(o2_h),
        .obs1_v_pos(o1_v), .obs2_v_pos(o2_v),
        .reset_game(rg), .game_state(st), .lives(lv), .score(sc), .hit(hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        tick;
        logic [9:0]  o1h;
        logic [8:0]  o1v;
        logic [9:0]  o2h;
        logic [8:0]  o2v;
        logic [1:0]  e_st;
        logic [1:0]  e_lv;
        logic [15:0] e_sc;
        logic        e_hit;
        logic        e_rg;
    } vec_t;

    vec_t vecs[$];

    // Obstacle positions used by the table builder for the next records
    logic [9:0] c_o1h, c_o2h;
    logic [8:0] c_o1v, c_o2v;

    int n_chk  = 0;
    int n_pass = 0;
    int cur    = -1;

    task automatic add(input logic s, input logic t, input logic [1:0] es,
                       input logic [1:0] el, input logic [15:0] esc,
                       input logic eh, input logic erg);
        vec_t v;
        v.start = s;    v.tick = t;
        v.o1h = c_o1h;  v.o1v = c_o1v;
        v.o2h = c_o2h;  v.o2v = c_o2v;
        v.e_st = es;    v.e_lv = el;  v.e_sc = esc;
        v.e_hit = eh;   v.e_rg = erg;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s (step %0d): got %h, expected %h", nm, cur, got, exp);
        else
            n_pass++;
    endtask

    task automatic chk_all(input logic [1:0] es, input logic [1:0] el,
                           input logic [15:0] esc, input logic eh, input logic erg);
        chk("game_state", 16'(st), 16'(es));
        chk("lives", 16'(lv), 16'(el));
        chk("score", sc, esc);
        chk("hit", 16'(hit), 16'(eh));
        chk("reset_game", 16'(rg), 16'(erg));
    endtask

    task automatic park_obstacles();
        c_o1h = 10'd300; c_o1v = 9'd100;
        c_o2h = 10'd500; c_o2v = 9'd100;
    endtask

    task automatic overlap_o1();
        c_o1h = 10'd120; c_o1v = 9'd380;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; tick = 1'b0; car_h = 10'd120;
        park_obstacles();
        o1_h = c_o1h; o1_v = c_o1v; o2_h = c_o2h; o2_v = c_o2v;

        // ---- build vector table ----
        add(1, 0, S_ID, 3, 0, 0, 1);   // button held through reset: no start
        add(1, 1, S_ID, 3, 0, 0, 1);   // frame_tick ignored in IDLE
        add(0, 0, S_ID, 3, 0, 0, 1);
        add(1, 1, S_PL, 3, 0, 0, 0);   // rise + tick: transition, no score
        add(0, 0, S_PL, 3, 0, 0, 0);
        add(1, 0, S_PL, 3, 0, 0, 0);   // rise ignored while playing
        for (int i = 1; i <= 10; i++) add(1, 1, S_PL, 3, 16'(i), 0, 0);
        c_o1h = 10'd160; c_o1v = 9'd380;              // touching right edge
        add(1, 0, S_PL, 3, 10, 0, 0);
        add(1, 1, S_PL, 3, 11, 0, 0);
        c_o1h = 10'd120; c_o1v = 9'd350;              // touching top edge
        add(1, 1, S_PL, 3, 12, 0, 0);
        c_o1h = 10'd70;  c_o1v = 9'd380;              // touching left edge
        add(1, 1, S_PL, 3, 13, 0, 0);
        overlap_o1();
        add(1, 1, S_PL, 3, 14, 1, 0);  // hit lags position by one cycle
        add(1, 1, S_CR, 2, 14, 1, 1);
        for (int i = 0; i < 59; i++) add(1, 1, S_CR, 2, 14, 1, 1);
        park_obstacles();
        add(1, 1, S_PL, 2, 14, 0, 0);  // 60th crash frame resumes play
        add(1, 1, S_PL, 2, 15, 0, 0);
        overlap_o1();
        add(1, 0, S_PL, 2, 15, 1, 0);
        add(1, 1, S_CR, 1, 15, 1, 1);
        for (int i = 0; i < 59; i++) add(1, 1, S_CR, 1, 15, 1, 1);
        park_obstacles();
        add(1, 1, S_PL, 1, 15, 0, 0);
        overlap_o1();
        c_o2h = 10'd130; c_o2v = 9'd420;              // both obstacles hit
        add(1, 0, S_PL, 1, 15, 1, 0);
        add(1, 1, S_CR, 0, 15, 1, 1);  // only one life lost
        for (int i = 0; i < 59; i++) add(1, 1, S_CR, 0, 15, 1, 1);
        add(1, 1, S_GO, 0, 15, 1, 1);
        add(1, 1, S_GO, 0, 15, 1, 1);  // frozen
        add(0, 1, S_GO, 0, 15, 1, 1);
        add(1, 1, S_PL, 3, 0, 1, 0);   // restart
        add(1, 1, S_CR, 2, 0, 1, 1);   // tick+hit in first PLAYING cycle

        // ---- reset with start held ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all(S_ID, 3, 0, 0, 1);

        // ---- apply table ----
        foreach (vecs[i]) begin
            cur   = i;
            start = vecs[i].start; tick = vecs[i].tick;
            o1_h  = vecs[i].o1h;   o1_v = vecs[i].o1v;
            o2_h  = vecs[i].o2h;   o2_v = vecs[i].o2v;
            @(posedge clk);
            #1;
            chk_all(vecs[i].e_st, vecs[i].e_lv, vecs[i].e_sc, vecs[i].e_hit, vecs[i].e_rg);
        end

        // ---- reset mid-CRASH with crash counter at 30 ----
        cur  = 1000;
        tick = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        tick = 1'b0;
        chk("crash_before_rst", 16'(st), 16'(S_CR));
        #2;
        rst = 1'b1;                    // asynchronous, away from any edge
        #1;
        chk_all(S_ID, 3, 0, 0, 1);

        // ---- score saturation ----
        cur = 2000;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        o1_h = 10'd300; o1_v = 9'd100; o2_h = 10'd500; o2_v = 9'd100;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        chk_all(S_PL, 3, 0, 0, 0);
        tick = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("score_fffe", sc, 16'hFFFE);
        @(posedge clk); #1;
        chk("score_ffff", sc, 16'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        chk("score_sat", sc, 16'hFFFF);
        chk("state_sat", 16'(st), 16'(S_PL));
        tick = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
